// File: rtl/dac_seq_pkg.sv
// dac_seq_pkg: shared types, widths and config check for the DAC playback sequencer
package dac_seq_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, DELAY, PLAY} state_e;
  localparam int DWIDTH_DEF = 64;
  localparam int BEAT_BYTES = DWIDTH_DEF / 8;
  localparam int ADDR_W = 32;
  localparam int PASS_W = 16;
  localparam int TRIG_W = 32;
  // A limit must land on a beat boundary and stay inside the waveform RAM.
  function automatic logic cfg_bad(input logic [ADDR_W-1:0] lim, input logic [ADDR_W-1:0] beat,
                                   input logic [ADDR_W-1:0] mem);
    return ((lim & (beat - ADDR_W'(1))) != '0) || (lim >= mem);
  endfunction
endpackage

// File: rtl/dac_seq_trig_detect.sv
// dac_seq_trig_detect: rising-edge detect on trig_in OR software trigger, only while armed
module dac_seq_trig_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic trig_i,
  input  logic sw_trig_i,
  input  logic armed_i,
  output logic trig_o
);
  logic trig_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) trig_q <= 1'b0;
    else trig_q <= trig_i;
  assign trig_o = armed_i & ((trig_i & ~trig_q) | sw_trig_i);
endmodule

// File: rtl/dac_playback_sequencer.sv
// dac_playback_sequencer: arm/trigger/delay/play control of a wrapping waveform streamer
module dac_playback_sequencer
  import dac_seq_pkg::*;
#(
  parameter int DWIDTH         = 64,
  parameter int MEM_SIZE_BYTES = 262144
) (
  input  logic              axis_clk,
  input  logic              axis_aresetn,
  input  logic              cfg_arm,
  input  logic              cfg_abort,
  input  logic              cfg_sw_trig,
  input  logic              trig_in,
  input  logic [ADDR_W-1:0] cfg_addr_limit,
  input  logic [31:0]       cfg_delay,
  input  logic [PASS_W-1:0] cfg_num_passes,
  input  logic              cfg_retrigger,
  output logic              stream_enable,
  output logic [ADDR_W-1:0] stream_addr_limit,
  output logic              armed,
  output logic              busy,
  output logic              done_pulse,
  output logic              cfg_err,
  output logic [PASS_W-1:0] pass_cnt,
  output logic [TRIG_W-1:0] trig_cnt
);
  localparam int BEAT  = DWIDTH / 8;
  localparam int SHIFT = $clog2(BEAT);
  logic [1:0] rst_sync_q;
  logic rst_n, trig, bad, last_beat, fin;
  state_e st_q, st_d;
  logic [ADDR_W-1:0] lim_q, beats_q, beat_q;
  logic [31:0] delay_q, dcnt_q;
  logic [PASS_W-1:0] npass_q, run_q, pass_cnt_q;
  logic [TRIG_W-1:0] trig_cnt_q;
  logic retrig_q, armed_q, busy_q, en_q, done_q, err_q;
  // Assertion is immediate; release reaches the core only after two clock edges.
  always_ff @(posedge axis_clk or negedge axis_aresetn)
    if (!axis_aresetn) rst_sync_q <= '0;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];
  dac_seq_trig_detect u_trig (
    .clk_i    (axis_clk),
    .rst_ni   (rst_n),
    .trig_i   (trig_in),
    .sw_trig_i(cfg_sw_trig),
    .armed_i  (armed_q),
    .trig_o   (trig)
  );
  assign bad       = cfg_bad(cfg_addr_limit, ADDR_W'(BEAT), ADDR_W'(MEM_SIZE_BYTES));
  assign last_beat = beat_q == beats_q;
  assign fin       = last_beat && npass_q != '0 && run_q == npass_q - PASS_W'(1);
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    st_d = (cfg_arm && !bad) ? ARMED : IDLE;
      ARMED:   st_d = trig ? (delay_q == '0 ? PLAY : DELAY) : ARMED;
      DELAY:   st_d = dcnt_q == '0 ? PLAY : DELAY;
      PLAY:    st_d = fin ? (retrig_q ? ARMED : IDLE) : PLAY;
      default: st_d = IDLE;
    endcase
    if (cfg_abort) st_d = IDLE;
  end
  always_ff @(posedge axis_clk or negedge rst_n)
    if (!rst_n) begin
      st_q       <= IDLE;
      lim_q      <= '0;
      beats_q    <= '0;
      beat_q     <= '0;
      delay_q    <= '0;
      dcnt_q     <= '0;
      npass_q    <= '0;
      run_q      <= '0;
      pass_cnt_q <= '0;
      trig_cnt_q <= '0;
      retrig_q   <= 1'b0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      st_q    <= st_d;
      armed_q <= st_d == ARMED;
      busy_q  <= st_d == DELAY || st_d == PLAY;
      en_q    <= st_d == PLAY;
      done_q  <= !cfg_abort && st_q == PLAY && fin;
      if (!cfg_abort) begin
        if (st_q == IDLE && cfg_arm) begin
          lim_q      <= cfg_addr_limit;
          beats_q    <= cfg_addr_limit >> SHIFT;
          delay_q    <= cfg_delay;
          npass_q    <= cfg_num_passes;
          retrig_q   <= cfg_retrigger;
          pass_cnt_q <= '0;
          err_q      <= bad;
        end
        if (st_q == ARMED && trig) begin
          trig_cnt_q <= trig_cnt_q + TRIG_W'(1);
          dcnt_q     <= delay_q - 32'd1;
          beat_q     <= '0;
          run_q      <= '0;
        end
        if (st_q == DELAY) dcnt_q <= dcnt_q - 32'd1;
        if (st_q == PLAY) begin
          beat_q <= last_beat ? '0 : beat_q + ADDR_W'(1);
          if (last_beat) begin
            run_q <= run_q + PASS_W'(1);
            if (pass_cnt_q != '1) pass_cnt_q <= pass_cnt_q + PASS_W'(1);
          end
        end
      end
    end
  assign stream_enable     = en_q;
  assign stream_addr_limit = lim_q;
  assign armed             = armed_q;
  assign busy              = busy_q;
  assign done_pulse        = done_q;
  assign cfg_err           = err_q;
  assign pass_cnt          = pass_cnt_q;
  assign trig_cnt          = trig_cnt_q;
endmodule

// File: tb/tb_dac_playback_sequencer.sv
// tb_dac_playback_sequencer: directed scenario tasks with hand-computed expectations
module tb_dac_playback_sequencer;
  logic        axis_clk = 1'b0;
  logic        axis_aresetn = 1'b0;
  logic        cfg_arm = 1'b0, cfg_abort = 1'b0, cfg_sw_trig = 1'b0, trig_in = 1'b0;
  logic [31:0] cfg_addr_limit = '0, cfg_delay = '0;
  logic [15:0] cfg_num_passes = '0;
  logic        cfg_retrigger = 1'b0;
  logic        stream_enable, armed, busy, done_pulse, cfg_err;
  logic [31:0] stream_addr_limit, trig_cnt;
  logic [15:0] pass_cnt;
  int n_chk = 0, n_fail = 0;

  always #5 axis_clk = ~axis_clk;

  dac_playback_sequencer #(.DWIDTH(64), .MEM_SIZE_BYTES(262144)) dut (
    .axis_clk         (axis_clk),
    .axis_aresetn     (axis_aresetn),
    .cfg_arm          (cfg_arm),
    .cfg_abort        (cfg_abort),
    .cfg_sw_trig      (cfg_sw_trig),
    .trig_in          (trig_in),
    .cfg_addr_limit   (cfg_addr_limit),
    .cfg_delay        (cfg_delay),
    .cfg_num_passes   (cfg_num_passes),
    .cfg_retrigger    (cfg_retrigger),
    .stream_enable    (stream_enable),
    .stream_addr_limit(stream_addr_limit),
    .armed            (armed),
    .busy             (busy),
    .done_pulse       (done_pulse),
    .cfg_err          (cfg_err),
    .pass_cnt         (pass_cnt),
    .trig_cnt         (trig_cnt)
  );

  task automatic tick;
    @(posedge axis_clk);
    #1;
  endtask

  task automatic arm(input logic [31:0] lim, input logic [31:0] dly, input logic [15:0] np, input logic rt);
    cfg_addr_limit = lim;
    cfg_delay = dly;
    cfg_num_passes = np;
    cfg_retrigger = rt;
    cfg_arm = 1'b1;
    tick;
    cfg_arm = 1'b0;
  endtask

  task automatic abort_pulse;
    cfg_abort = 1'b1;
    tick;
    cfg_abort = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) tick;
    axis_aresetn = 1'b1;
    repeat (3) tick;
    n_chk++; if (stream_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %0b want 0", stream_enable); end
    n_chk++; if (armed !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_flags: armed=%0b busy=%0b want 0 0", armed, busy); end
    n_chk++; if (cfg_err !== 1'b0 || done_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_done: err=%0b done=%0b want 0 0", cfg_err, done_pulse); end
    n_chk++; if (trig_cnt !== 32'd0 || pass_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_counts: trig=%0d pass=%0d want 0 0", trig_cnt, pass_cnt); end
    n_chk++; if (stream_addr_limit !== 32'd0) begin n_fail++; $display("FAIL reset_limit: got %h want 0", stream_addr_limit); end
  endtask

  task automatic test_single_pass;
    int on, dn;
    on = 0; dn = 0;
    arm(32'h38, 32'd0, 16'd2, 1'b0);
    n_chk++; if (armed !== 1'b1) begin n_fail++; $display("FAIL single_armed: got %0b want 1", armed); end
    n_chk++; if (stream_addr_limit !== 32'h38) begin n_fail++; $display("FAIL single_limit: got %h want 38", stream_addr_limit); end
    cfg_sw_trig = 1'b1;
    tick;
    cfg_sw_trig = 1'b0;
    n_chk++; if (stream_enable !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL single_play_next: en=%0b busy=%0b want 1 1", stream_enable, busy); end
    for (int i = 0; i < 30; i++) begin
      if (stream_enable) on++;
      if (done_pulse) dn++;
      tick;
    end
    n_chk++; if (on != 16) begin n_fail++; $display("FAIL single_enable_len: got %0d want 16", on); end
    n_chk++; if (dn != 1) begin n_fail++; $display("FAIL single_done: got %0d want 1", dn); end
    n_chk++; if (pass_cnt !== 16'd2) begin n_fail++; $display("FAIL single_pass_cnt: got %0d want 2", pass_cnt); end
    n_chk++; if (armed !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: armed=%0b busy=%0b want 0 0", armed, busy); end
    n_chk++; if (trig_cnt !== 32'd1) begin n_fail++; $display("FAIL single_trig_cnt: got %0d want 1", trig_cnt); end
  endtask

  task automatic test_retrigger;
    int on, dn, first;
    arm(32'h18, 32'd5, 16'd1, 1'b1);
    for (int b = 0; b < 2; b++) begin
      on = 0; dn = 0; first = -1;
      trig_in = 1'b1;
      for (int i = 0; i < 40; i++) begin
        tick;
        if (i == 2) trig_in = 1'b0;
        if (stream_enable) begin on++; if (first < 0) first = i; end
        if (done_pulse) dn++;
      end
      n_chk++; if (first != 5) begin n_fail++; $display("FAIL retrig_latency_%0d: got %0d want 5", b, first); end
      n_chk++; if (on != 4) begin n_fail++; $display("FAIL retrig_burst_%0d: got %0d want 4", b, on); end
      n_chk++; if (dn != 1) begin n_fail++; $display("FAIL retrig_done_%0d: got %0d want 1", b, dn); end
    end
    n_chk++; if (trig_cnt !== 32'd3) begin n_fail++; $display("FAIL retrig_trig_cnt: got %0d want 3", trig_cnt); end
    n_chk++; if (armed !== 1'b1) begin n_fail++; $display("FAIL retrig_armed: got %0b want 1", armed); end
    n_chk++; if (pass_cnt !== 16'd2) begin n_fail++; $display("FAIL retrig_pass_cnt: got %0d want 2", pass_cnt); end
    abort_pulse;
    n_chk++; if (armed !== 1'b0) begin n_fail++; $display("FAIL retrig_abort: armed=%0b want 0", armed); end
  endtask

  task automatic test_cfg_err;
    arm(32'h1C, 32'd0, 16'd1, 1'b0);
    n_chk++; if (cfg_err !== 1'b1 || armed !== 1'b0) begin n_fail++; $display("FAIL err_unaligned: err=%0b armed=%0b want 1 0", cfg_err, armed); end
    arm(32'h40000, 32'd0, 16'd1, 1'b0);
    n_chk++; if (cfg_err !== 1'b1 || armed !== 1'b0) begin n_fail++; $display("FAIL err_oversize: err=%0b armed=%0b want 1 0", cfg_err, armed); end
    arm(32'h20, 32'd0, 16'd1, 1'b0);
    n_chk++; if (cfg_err !== 1'b0 || armed !== 1'b1) begin n_fail++; $display("FAIL err_clear: err=%0b armed=%0b want 0 1", cfg_err, armed); end
    n_chk++; if (stream_addr_limit !== 32'h20) begin n_fail++; $display("FAIL err_limit: got %h want 20", stream_addr_limit); end
    abort_pulse;
    arm(32'h3FFF8, 32'd0, 16'd1, 1'b0);
    n_chk++; if (cfg_err !== 1'b0 || armed !== 1'b1) begin n_fail++; $display("FAIL err_max_limit: err=%0b armed=%0b want 0 1", cfg_err, armed); end
    abort_pulse;
  endtask

  task automatic test_endless;
    int on, dn;
    on = 0; dn = 0;
    arm(32'h08, 32'd0, 16'd0, 1'b0);
    cfg_sw_trig = 1'b1;
    tick;
    cfg_sw_trig = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (stream_enable) on++;
      if (done_pulse) dn++;
      tick;
    end
    n_chk++; if (on != 100 || stream_enable !== 1'b1) begin n_fail++; $display("FAIL endless_run: on=%0d en=%0b want 100 1", on, stream_enable); end
    abort_pulse;
    n_chk++; if (stream_enable !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL endless_abort: en=%0b busy=%0b want 0 0", stream_enable, busy); end
    n_chk++; if (dn != 0 || done_pulse !== 1'b0) begin n_fail++; $display("FAIL endless_done: count=%0d now=%0b want 0 0", dn, done_pulse); end
    n_chk++; if (pass_cnt !== 16'd50) begin n_fail++; $display("FAIL endless_pass_cnt: got %0d want 50", pass_cnt); end
    n_chk++; if (trig_cnt !== 32'd4) begin n_fail++; $display("FAIL endless_trig_cnt: got %0d want 4", trig_cnt); end
  endtask

  task automatic test_ignored;
    int on, dn;
    on = 0; dn = 0;
    arm(32'h18, 32'd5, 16'd1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      trig_in = (i == 0 || i == 2 || i == 6);
      cfg_sw_trig = (i == 3 || i == 7);
      tick;
      if (stream_enable) on++;
      if (done_pulse) dn++;
    end
    trig_in = 1'b0;
    cfg_sw_trig = 1'b0;
    n_chk++; if (trig_cnt !== 32'd5) begin n_fail++; $display("FAIL ignored_trig_cnt: got %0d want 5", trig_cnt); end
    n_chk++; if (on != 4 || dn != 1) begin n_fail++; $display("FAIL ignored_burst: on=%0d done=%0d want 4 1", on, dn); end
    n_chk++; if (armed !== 1'b0) begin n_fail++; $display("FAIL ignored_idle: armed=%0b want 0", armed); end
    cfg_addr_limit = 32'h20;
    cfg_arm = 1'b1;
    cfg_abort = 1'b1;
    tick;
    cfg_arm = 1'b0;
    cfg_abort = 1'b0;
    n_chk++; if (armed !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL arm_abort: armed=%0b busy=%0b want 0 0", armed, busy); end
    cfg_arm = 1'b1;
    cfg_sw_trig = 1'b1;
    trig_in = 1'b1;
    tick;
    cfg_arm = 1'b0;
    cfg_sw_trig = 1'b0;
    n_chk++; if (armed !== 1'b1 || trig_cnt !== 32'd5) begin n_fail++; $display("FAIL arm_with_trig: armed=%0b trig=%0d want 1 5", armed, trig_cnt); end
    tick;
    n_chk++; if (armed !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL held_level: armed=%0b busy=%0b want 1 0", armed, busy); end
    cfg_addr_limit = 32'h1C;
    cfg_arm = 1'b1;
    tick;
    cfg_arm = 1'b0;
    n_chk++; if (cfg_err !== 1'b0 || armed !== 1'b1 || stream_addr_limit !== 32'h20) begin n_fail++; $display("FAIL arm_in_armed: err=%0b armed=%0b lim=%h want 0 1 20", cfg_err, armed, stream_addr_limit); end
    trig_in = 1'b0;
    abort_pulse;
  endtask

  task automatic test_reset_mid_play;
    arm(32'h08, 32'd0, 16'd0, 1'b0);
    cfg_sw_trig = 1'b1;
    tick;
    cfg_sw_trig = 1'b0;
    repeat (3) tick;
    n_chk++; if (stream_enable !== 1'b1 || pass_cnt !== 16'd1) begin n_fail++; $display("FAIL pre_reset: en=%0b pass=%0d want 1 1", stream_enable, pass_cnt); end
    axis_aresetn = 1'b0;
    #1;
    n_chk++; if (stream_enable !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL async_reset: en=%0b busy=%0b want 0 0", stream_enable, busy); end
    repeat (2) tick;
    axis_aresetn = 1'b1;
    repeat (3) tick;
    n_chk++; if (trig_cnt !== 32'd0 || pass_cnt !== 16'd0) begin n_fail++; $display("FAIL post_reset_counts: trig=%0d pass=%0d want 0 0", trig_cnt, pass_cnt); end
    n_chk++; if (stream_addr_limit !== 32'd0 || armed !== 1'b0 || stream_enable !== 1'b0) begin n_fail++; $display("FAIL post_reset_state: lim=%h armed=%0b en=%0b want 0 0 0", stream_addr_limit, armed, stream_enable); end
  endtask

  initial begin
    test_reset;
    test_single_pass;
    test_retrigger;
    test_cfg_err;
    test_endless;
    test_ignored;
    test_reset_mid_play;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dac_playback_sequencer.md
DAC_PLAYBACK_SEQUENCER -- requirements
Module: dac_playback_sequencer

Interface
REQ-001 SHALL have parameters: DWIDTH, 64, streamer data width in bits; MEM_SIZE_BYTES, 262144, waveform RAM size in bytes.
REQ-002 SHALL have ports: axis_clk  in  1  sole clock; axis_aresetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: cfg_arm  in  1  arm pulse; cfg_abort  in  1  abort pulse; cfg_sw_trig  in  1  software trigger pulse; trig_in  in  1  external trigger level, synchronous to axis_clk.
REQ-004 SHALL have ports: cfg_addr_limit  in  32  last waveform byte address; cfg_delay  in  32  trigger-to-play cycles; cfg_num_passes  in  16  passes per trigger, 0 = endless; cfg_retrigger  in  1  re-arm after done.
REQ-005 SHALL have ports: stream_enable  out  1  streamer enable; stream_addr_limit  out  32  streamer wrap address.
REQ-006 SHALL have ports: armed, busy, done_pulse, cfg_err  out  1 each; pass_cnt  out  16  passes completed; trig_cnt  out  32  accepted triggers.

Function
REQ-007 SHALL implement states IDLE, ARMED, DELAY, PLAY; all outputs registered.
REQ-008 IDLE: on cfg_arm, SHALL latch all cfg_* inputs, clear pass_cnt, check config, and go to ARMED next cycle.
REQ-009 Config check: cfg_addr_limit not a multiple of DWIDTH/8, or >= MEM_SIZE_BYTES -> cfg_err=1, stay IDLE; cfg_err clears on the next valid arm.
REQ-010 stream_addr_limit SHALL equal the latched limit from arm until the next arm.
REQ-011 ARMED: armed=1; a trigger is a rising edge of trig_in (registered edge detect) or cfg_sw_trig=1; trigger -> trig_cnt+1, go to DELAY.
REQ-012 DELAY: down-counter loaded with latched delay; go to PLAY when it reaches 0; delay 0 -> PLAY on the cycle after the trigger.
REQ-013 PLAY: stream_enable=1; beat counter runs 0..L, L = limit/(DWIDTH/8); at beat L pass_cnt+1 (saturating at 0xFFFF) and beat counter returns to 0.
REQ-014 SHALL hold stream_enable high for exactly N*(L+1) consecutive cycles per trigger (N = latched passes, N>0), matching the streamer wrap period.
REQ-015 On completion of pass N: done_pulse high for 1 cycle and stream_enable low the next cycle; next state ARMED if latched retrigger=1, else IDLE.
REQ-016 N=0: PLAY continues until abort; done_pulse is never asserted.
REQ-017 busy SHALL be 1 in DELAY and PLAY, 0 otherwise.
REQ-018 Triggers in DELAY or PLAY SHALL be ignored and not counted.
REQ-019 cfg_abort in any state: go to IDLE next cycle, stream_enable low, no done_pulse; pass_cnt and trig_cnt hold.
REQ-020 Simultaneous cfg_abort and cfg_arm: abort wins. cfg_arm outside IDLE: ignored.
REQ-021 Trigger in the same cycle as cfg_arm SHALL NOT be accepted.
REQ-022 trig_cnt SHALL wrap modulo 2^32 and clear only on reset.

Reset
REQ-023 axis_aresetn low SHALL asynchronously force IDLE and clear all counters, latched config, and outputs (stream_addr_limit=0, stream_enable=0, cfg_err=0).
REQ-024 Reset mid-PLAY SHALL drop stream_enable immediately; deassertion SHALL be synchronized to axis_clk before leaving reset.

Structure
REQ-025 Package dac_seq_pkg SHALL hold the state enum, BEAT_BYTES = DWIDTH/8, and the counter widths.
REQ-026 Trigger edge detection SHALL be a sub-module dac_seq_trig_detect (registered trig_in, rise = trig_in & ~trig_q, OR cfg_sw_trig, gated by armed).

Verification
REQ-027 Arm limit=0x38, delay=0, passes=2, sw trig -> PLAY next cycle, stream_enable high 16 cycles, done_pulse once, pass_cnt=2, IDLE.
REQ-028 Arm limit=0x18, delay=5, retrigger=1, passes=1, two trig_in edges 40 cycles apart -> two 4-cycle enable bursts, each 6 cycles after its edge, trig_cnt=2, ends ARMED.
REQ-029 Arm limit=0x1C (unaligned) -> cfg_err=1, state IDLE; re-arm limit=0x20 -> cfg_err=0, armed=1.
REQ-030 Passes=0, limit=0x08, trigger, abort after 100 cycles -> enable low next cycle, no done_pulse, pass_cnt=50.
REQ-031 trig_in pulses during DELAY and PLAY -> trig_cnt unchanged; arm+abort same cycle -> stays IDLE.
REQ-032 axis_aresetn low mid-PLAY -> stream_enable=0 without clock edge; all counters 0 after release.
